// File: rtl/logic_issue_unit.sv
// logic_issue_unit
//   Issue / writeback stage in front of a combinational 16-bit logic unit.
//   Two pipeline stages:
//     EX  : holds an accepted instruction and drives the logic unit inputs
//     OUT : captures the logic unit result and presents it downstream
//   The register file is read at issue time. A result that is being
//   written back in the same cycle is forwarded to the issuing instruction.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       instruction handshake
//   in_opcode, in_rd,
//   in_rs1, in_rs2            instruction fields (opcode 1xxx legal)
//   wr_en, wr_addr, wr_data   host register-file load port
//   lu_opcode, lu_a, lu_b     to logic unit
//   lu_result, lu_sel         from logic unit (combinational)
//   out_valid / out_ready     result handshake
//   out_result, out_zero,
//   out_rd, out_err           result payload
module logic_issue_unit #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opcode,
    input  logic [AW-1:0]     in_rd,
    input  logic [AW-1:0]     in_rs1,
    input  logic [AW-1:0]     in_rs2,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [3:0]        lu_opcode,
    output logic [DATA_W-1:0] lu_a,
    output logic [DATA_W-1:0] lu_b,
    input  logic [DATA_W-1:0] lu_result,
    input  logic              lu_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [AW-1:0]     out_rd,
    output logic              out_err
);

    logic [DATA_W-1:0] rf_q [NREG];

    logic              ex_valid_q, ex_valid_d;
    logic [3:0]        ex_opcode_q, ex_opcode_d;
    logic [AW-1:0]     ex_rd_q, ex_rd_d;
    logic [DATA_W-1:0] ex_a_q, ex_a_d;
    logic [DATA_W-1:0] ex_b_q, ex_b_d;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic              out_zero_q, out_zero_d;
    logic [AW-1:0]     out_rd_q, out_rd_d;
    logic              out_err_q, out_err_d;

    logic              out_free;
    logic              ex_adv;
    logic              accept;
    logic              ex_legal;
    logic              wb_en;
    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    assign out_free = !out_valid_q || out_ready;
    assign ex_adv   = ex_valid_q && out_free;
    // in_ready is built only from stage state, never from in_valid
    assign in_ready = !ex_valid_q || ex_adv;
    assign accept   = in_valid && in_ready;
    assign ex_legal = ex_opcode_q[3];
    assign wb_en    = ex_adv && ex_legal;

    // Forward the result being written back this cycle; host writes are
    // deliberately not forwarded.
    assign opnd_a = (wb_en && (ex_rd_q == in_rs1)) ? lu_result : rf_q[in_rs1];
    assign opnd_b = (wb_en && (ex_rd_q == in_rs2)) ? lu_result : rf_q[in_rs2];

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_opcode_d  = ex_opcode_q;
        ex_rd_d      = ex_rd_q;
        ex_a_d       = ex_a_q;
        ex_b_d       = ex_b_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_zero_d   = out_zero_q;
        out_rd_d     = out_rd_q;
        out_err_d    = out_err_q;

        if (accept) begin
            ex_valid_d  = 1'b1;
            ex_opcode_d = in_opcode;
            ex_rd_d     = in_rd;
            ex_a_d      = opnd_a;
            ex_b_d      = opnd_b;
        end else if (ex_adv) begin
            ex_valid_d = 1'b0;
        end

        if (ex_adv) begin
            out_valid_d  = 1'b1;
            out_result_d = ex_legal ? lu_result : '0;
            out_zero_d   = ex_legal ? lu_sel : 1'b0;
            out_rd_d     = ex_rd_q;
            out_err_d    = !ex_legal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ex_opcode_q  <= '0;
            ex_rd_q      <= '0;
            ex_a_q       <= '0;
            ex_b_q       <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_zero_q   <= 1'b0;
            out_rd_q     <= '0;
            out_err_q    <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_opcode_q  <= ex_opcode_d;
            ex_rd_q      <= ex_rd_d;
            ex_a_q       <= ex_a_d;
            ex_b_q       <= ex_b_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_zero_q   <= out_zero_d;
            out_rd_q     <= out_rd_d;
            out_err_q    <= out_err_d;
        end
    end

    // Writeback has priority over a host write to the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wb_en && (ex_rd_q == AW'(i)))
                    rf_q[i] <= lu_result;
                else if (wr_en && (wr_addr == AW'(i)))
                    rf_q[i] <= wr_data;
            end
        end
    end

    assign lu_opcode  = ex_opcode_q;
    assign lu_a       = ex_a_q;
    assign lu_b       = ex_b_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_zero   = out_zero_q;
    assign out_rd     = out_rd_q;
    assign out_err    = out_err_q;

endmodule

// File: tb/tb_logic_issue_unit.sv
// Testbench for logic_issue_unit: a behavioural logic unit model is wired to
// the lu_* ports, instructions come from vector tables and the results are
// checked in acceptance order by a monitor against hand-computed values.
module tb_logic_issue_unit;

    localparam int DATA_W = 16;
    localparam int AW     = 3;

    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_NAND = 4'b1001;
    localparam logic [3:0] OP_NOR  = 4'b1010;
    localparam logic [3:0] OP_OR   = 4'b1011;
    localparam logic [3:0] OP_NOT  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;
    localparam logic [3:0] OP_XNOR = 4'b1110;
    localparam logic [3:0] OP_NEG  = 4'b1111;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_opcode;
    logic [AW-1:0]     in_rd, in_rs1, in_rs2;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        lu_opcode;
    logic [DATA_W-1:0] lu_a, lu_b;
    logic [DATA_W-1:0] lu_result;
    logic              lu_sel;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_zero;
    logic [AW-1:0]     out_rd;
    logic              out_err;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [3:0]        op;
        logic [AW-1:0]     rd;
        logic [AW-1:0]     rs1;
        logic [AW-1:0]     rs2;
        logic [DATA_W-1:0] res;
        logic              zero;
        logic              err;
    } vec_t;

    vec_t exp_q[$];

    logic_issue_unit dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .lu_opcode(lu_opcode), .lu_a(lu_a), .lu_b(lu_b),
        .lu_result(lu_result), .lu_sel(lu_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero),
        .out_rd(out_rd), .out_err(out_err)
    );

    always #5 clk = ~clk;

    // Logic unit model
    always_comb begin
        lu_result = '0;
        case (lu_opcode)
            OP_AND:  lu_result = lu_a & lu_b;
            OP_NAND: lu_result = ~(lu_a & lu_b);
            OP_NOR:  lu_result = ~(lu_a | lu_b);
            OP_OR:   lu_result = lu_a | lu_b;
            OP_NOT:  lu_result = ~lu_a;
            OP_XOR:  lu_result = lu_a ^ lu_b;
            OP_XNOR: lu_result = ~(lu_a ^ lu_b);
            OP_NEG:  lu_result = -lu_a;
            default: lu_result = '0;
        endcase
        lu_sel = (lu_result == '0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Result monitor: one line per completed transaction
    always begin
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_result: got rd=%0d result=0x%0h, expected none", out_rd, out_result);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                $display("result rd=%0d data=0x%04h zero=%0d err=%0d", out_rd, out_result, out_zero, out_err);
                check("out_result", 32'(out_result), 32'(e.res));
                check("out_zero", 32'(out_zero), 32'(e.zero));
                check("out_rd", 32'(out_rd), 32'(e.rd));
                check("out_err", 32'(out_err), 32'(e.err));
            end
        end
    end

    // Drive an instruction, wait (bounded) for acceptance, queue its expectation.
    task automatic issue(input vec_t v);
        int n = 0;
        in_valid  = 1'b1;
        in_opcode = v.op;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check("issue_timeout", 32'(in_ready), 32'd1);
        end else begin
            exp_q.push_back(v);
            $display("issue op=%b rd=%0d rs1=%0d rs2=%0d", v.op, v.rd, v.rs1, v.rs2);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        $display("host write r%0d=0x%04h", a, d);
    endtask

    function automatic vec_t mk(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                                input logic [15:0] res, input logic zero, input logic err);
        vec_t v;
        v.op = op; v.rd = AW'(rd); v.rs1 = AW'(rs1); v.rs2 = AW'(rs2);
        v.res = res; v.zero = zero; v.err = err;
        return v;
    endfunction

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        #3;
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
    endtask

    vec_t tbl1[3];
    vec_t tbl2[8];
    vec_t tbl3[8];
    logic [3:0]        hold_op;
    logic [DATA_W-1:0] hold_a, hold_b;

    initial begin
        // r1=0x00FF r2=0x0F0F r3=AND -> 0x000F
        tbl1[0] = mk(OP_XOR, 4, 1, 1, 16'h0000, 1'b1, 1'b0);
        tbl1[1] = mk(OP_OR,  5, 4, 2, 16'h0F0F, 1'b0, 1'b0);
        tbl1[2] = mk(OP_OR,  3, 3, 3, 16'h000F, 1'b0, 1'b0);
        // after r1=0x0001
        tbl2[0] = mk(OP_NEG,  6, 1, 0, 16'hFFFF, 1'b0, 1'b0);
        tbl2[1] = mk(OP_NOT,  7, 0, 0, 16'hFFFF, 1'b0, 1'b0);
        tbl2[2] = mk(4'b0011, 6, 1, 2, 16'h0000, 1'b0, 1'b1);
        tbl2[3] = mk(OP_OR,   6, 6, 6, 16'hFFFF, 1'b0, 1'b0);
        tbl2[4] = mk(OP_NAND, 5, 5, 2, 16'hF0F0, 1'b0, 1'b0);
        tbl2[5] = mk(OP_NOR,  5, 5, 0, 16'h0F0F, 1'b0, 1'b0);
        tbl2[6] = mk(OP_XNOR, 4, 5, 2, 16'hFFFF, 1'b0, 1'b0);
        tbl2[7] = mk(OP_AND,  3, 4, 1, 16'h0001, 1'b0, 1'b0);
        // register readback after reset: all zero
        for (int i = 0; i < 8; i++) tbl3[i] = mk(OP_OR, i, i, i, 16'h0000, 1'b1, 1'b0);

        rst = 1'b1; in_valid = 1'b0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_lu_opcode", 32'(lu_opcode), 32'd0);
        check("reset_lu_a", 32'(lu_a), 32'd0);
        check("reset_lu_b", 32'(lu_b), 32'd0);
        check("reset_out_result", 32'(out_result), 32'd0);
        check("reset_out_err", 32'(out_err), 32'd0);
        @(negedge clk);

        host_write(3'd1, 16'h00FF);
        host_write(3'd2, 16'h0F0F);

        // AND r3,r1,r2 with latency check
        issue(mk(OP_AND, 3, 1, 2, 16'h000F, 1'b0, 1'b0));
        #2;
        check("lat_out_valid_e0", 32'(out_valid), 32'd0);
        check("lat_lu_opcode", 32'(lu_opcode), 32'(OP_AND));
        check("lat_lu_a", 32'(lu_a), 32'h00FF);
        check("lat_lu_b", 32'(lu_b), 32'h0F0F);
        @(negedge clk);
        #2;
        check("lat_out_valid_e1", 32'(out_valid), 32'd1);

        // Back-to-back dependent chain
        for (int i = 0; i < 3; i++) issue(tbl1[i]);
        drain();

        host_write(3'd1, 16'h0001);
        for (int i = 0; i < 8; i++) issue(tbl2[i]);
        drain();

        // Writeback and host write to the same register: writeback wins
        issue(mk(OP_NOT, 4, 0, 0, 16'hFFFF, 1'b0, 1'b0));
        host_write(3'd4, 16'h1234);
        issue(mk(OP_OR, 4, 4, 4, 16'hFFFF, 1'b0, 1'b0));
        drain();

        // Stall: out_ready low with three instructions pending
        out_ready = 1'b0;
        issue(mk(OP_OR,  1, 1, 2, 16'h0F0F, 1'b0, 1'b0));
        issue(mk(OP_XOR, 2, 1, 2, 16'h0000, 1'b1, 1'b0));
        in_valid = 1'b1; in_opcode = OP_AND; in_rd = 3'd3; in_rs1 = 3'd2; in_rs2 = 3'd1;
        #2;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_lu_opcode", 32'(lu_opcode), 32'(OP_XOR));
        check("stall_lu_a_fwd", 32'(lu_a), 32'h0F0F);
        hold_op = lu_opcode; hold_a = lu_a; hold_b = lu_b;
        repeat (3) @(negedge clk);
        #2;
        check("stall_in_ready_hold", 32'(in_ready), 32'd0);
        check("stall_lu_op_hold", 32'(lu_opcode), 32'(hold_op));
        check("stall_lu_a_hold", 32'(lu_a), 32'(hold_a));
        check("stall_lu_b_hold", 32'(lu_b), 32'(hold_b));
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_out_result", 32'(out_result), 32'h0F0F);
        check("stall_out_rd", 32'(out_rd), 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        issue(mk(OP_AND, 3, 2, 1, 16'h0000, 1'b1, 1'b0));
        drain();

        // Reset with EX and output both occupied
        out_ready = 1'b0;
        issue(mk(OP_NOT, 1, 0, 0, 16'hFFFF, 1'b0, 1'b0));
        issue(mk(OP_NOT, 2, 0, 0, 16'hFFFF, 1'b0, 1'b0));
        #3;
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        check("pre_rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_lu_opcode", 32'(lu_opcode), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) issue(tbl3[i]);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
